// File: rtl/dcache_refill.sv
// Byte-serial responder for dcache loads/stores over a byte-wide RAM bus.
// Loads are assembled little-endian; every completed access is echoed on the fill port.
module dcache_refill #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        nbyte_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic [MEM_AW-1:0] mem_a_o,
    output logic              mem_wr_o,
    output logic [7:0]        mem_dout_o,
    input  logic [7:0]        mem_din_i,
    output logic              fill_we_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [1:0]        fill_nbyte_o,
    output logic [31:0]       fill_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] nbyte_to_len(input logic [1:0] nb);
        logic [2:0] len;
        case (nb)
            2'b00:   len = 3'd1;
            2'b01:   len = 3'd2;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] fill_size(input logic [1:0] nb);
        logic [1:0] sz;
        case (nb)
            2'b11:   sz = 2'b10;
            default: sz = nb;
        endcase
        return sz;
    endfunction

    state_t             state_r, state_s;
    logic [2:0]         k_r, k_s;
    logic [2:0]         len_r, len_s;
    logic [1:0]         nbyte_r, nbyte_s;
    logic [ADDR_W-1:0]  addr_r, addr_s;
    logic [31:0]        wdata_r, wdata_s;
    logic [31:0]        asm_r, asm_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               fill_we_r, fill_we_s;
    logic [31:0]        rdata_r, rdata_s;
    logic [MEM_AW-1:0]  mem_a_r, mem_a_s;
    logic               mem_wr_r, mem_wr_s;
    logic [7:0]         mem_dout_r, mem_dout_s;
    logic [ADDR_W-1:0]  fill_addr_r, fill_addr_s;
    logic [1:0]         fill_nbyte_r, fill_nbyte_s;
    logic [31:0]        fill_data_r, fill_data_s;
    logic               last_slot_s;
    logic [1:0]         cap_idx_s;

    // Slot k_r drives address k_r-1 on the bus; the final slot (len+1) captures the last read byte.
    assign last_slot_s = (k_r == (len_r + 3'd1));
    assign cap_idx_s   = k_r[1:0] - 2'd2;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else if (rdy) begin
            state_r <= state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_i) begin
                    state_s = we_i ? ST_STORE : ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD, ST_STORE: begin
                if (last_slot_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        k_s          = k_r;
        len_s        = len_r;
        nbyte_s      = nbyte_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        asm_s        = asm_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        fill_we_s    = 1'b0;
        rdata_s      = rdata_r;
        mem_a_s      = mem_a_r;
        mem_wr_s     = 1'b0;
        mem_dout_s   = mem_dout_r;
        fill_addr_s  = fill_addr_r;
        fill_nbyte_s = fill_nbyte_r;
        fill_data_s  = fill_data_r;
        case (state_r)
            ST_IDLE: begin
                if (req_i) begin
                    k_s     = 3'd0;
                    len_s   = nbyte_to_len(nbyte_i);
                    nbyte_s = fill_size(nbyte_i);
                    addr_s  = addr_i;
                    wdata_s = wdata_i;
                    asm_s   = 32'h0000_0000;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            ST_LOAD, ST_STORE: begin
                k_s = k_r + 3'd1;
                if (k_r < len_r) begin
                    mem_a_s    = addr_r[MEM_AW-1:0] + MEM_AW'(k_r);
                    mem_wr_s   = (state_r == ST_STORE);
                    mem_dout_s = wdata_r[{k_r[1:0], 3'b000} +: 8];
                end else begin
                    mem_wr_s   = 1'b0;
                end
                if ((state_r == ST_LOAD) && (k_r >= 3'd2)) begin
                    asm_s[{cap_idx_s, 3'b000} +: 8] = mem_din_i;
                end else begin
                    asm_s = asm_r;
                end
                if (last_slot_s) begin
                    done_s       = 1'b1;
                    fill_we_s    = 1'b1;
                    fill_addr_s  = addr_r;
                    fill_nbyte_s = nbyte_r;
                    if (state_r == ST_LOAD) begin
                        rdata_s     = asm_s;
                        fill_data_s = asm_s;
                    end else begin
                        rdata_s     = rdata_r;
                        fill_data_s = wdata_r;
                    end
                end else begin
                    done_s    = 1'b0;
                    fill_we_s = 1'b0;
                end
            end
            ST_DONE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs; rdy=0 freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_r          <= 3'd0;
            len_r        <= 3'd0;
            nbyte_r      <= 2'b00;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= 32'h0000_0000;
            asm_r        <= 32'h0000_0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fill_we_r    <= 1'b0;
            rdata_r      <= 32'h0000_0000;
            mem_a_r      <= {MEM_AW{1'b0}};
            mem_wr_r     <= 1'b0;
            mem_dout_r   <= 8'h00;
            fill_addr_r  <= {ADDR_W{1'b0}};
            fill_nbyte_r <= 2'b00;
            fill_data_r  <= 32'h0000_0000;
        end else if (rdy) begin
            k_r          <= k_s;
            len_r        <= len_s;
            nbyte_r      <= nbyte_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            asm_r        <= asm_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            fill_we_r    <= fill_we_s;
            rdata_r      <= rdata_s;
            mem_a_r      <= mem_a_s;
            mem_wr_r     <= mem_wr_s;
            mem_dout_r   <= mem_dout_s;
            fill_addr_r  <= fill_addr_s;
            fill_nbyte_r <= fill_nbyte_s;
            fill_data_r  <= fill_data_s;
        end else begin
            k_r <= k_r;
        end
    end

    // Strobes are masked while stalled so the pulse lands on the first rdy=1 cycle
    assign busy_o       = busy_r;
    assign done_o       = done_r & rdy;
    assign fill_we_o    = fill_we_r & rdy;
    assign mem_wr_o     = mem_wr_r & rdy;
    assign rdata_o      = rdata_r;
    assign mem_a_o      = mem_a_r;
    assign mem_dout_o   = mem_dout_r;
    assign fill_addr_o  = fill_addr_r;
    assign fill_nbyte_o = fill_nbyte_r;
    assign fill_data_o  = fill_data_r;

endmodule

// File: tb/tb_dcache_refill.sv
// Randomized self-checking bench for dcache_refill with a byte-array RAM and
// an address-level reference model of expected bus writes, load data and timing.
module tb_dcache_refill;
    localparam int ADDR_W = 32;
    localparam int MEM_AW = 17;
    localparam int MEM_SZ = 1 << MEM_AW;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [1:0]        nbyte_i;
    logic [31:0]       wdata_i;
    logic              busy_o;
    logic              done_o;
    logic [31:0]       rdata_o;
    logic [MEM_AW-1:0] mem_a_o;
    logic              mem_wr_o;
    logic [7:0]        mem_dout_o;
    logic [7:0]        mem_din_i;
    logic              fill_we_o;
    logic [ADDR_W-1:0] fill_addr_o;
    logic [1:0]        fill_nbyte_o;
    logic [31:0]       fill_data_o;

    dcache_refill #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .nbyte_i(nbyte_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
        .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o), .mem_dout_o(mem_dout_o),
        .mem_din_i(mem_din_i), .fill_we_o(fill_we_o), .fill_addr_o(fill_addr_o),
        .fill_nbyte_o(fill_nbyte_o), .fill_data_o(fill_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ram     [0:MEM_SZ-1];
    logic [7:0]  ref_mem [0:MEM_SZ-1];
    logic        ram_clr;
    logic        pk_we;
    logic [16:0] pk_a;
    logic [7:0]  pk_d;
    logic [24:0] wr_q [$];
    int          done_cnt;
    int          errors;
    int          checks;
    logic [31:0] last_rd;

    function automatic logic [7:0] bg(input logic [16:0] a);
        return a[7:0] ^ {a[16:13], a[12:9]} ^ 8'h5A;
    endfunction

    function automatic int nbytes(input logic [1:0] nb);
        return (nb == 2'b00) ? 1 : (nb == 2'b01) ? 2 : 4;
    endfunction

    // RAM: synchronous read, write on mem_wr_o; also logs bus writes and done pulses
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < MEM_SZ; i++) ram[i] <= bg(17'(i));
        end else if (pk_we) begin
            ram[pk_a] <= pk_d;
        end else if (mem_wr_o) begin
            ram[mem_a_o] <= mem_dout_o;
        end
        mem_din_i <= ram[mem_a_o];
        if (mem_wr_o) wr_q.push_back({mem_a_o, mem_dout_o});
        if (done_o) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_we = 1'b1; pk_a = a; pk_d = d;
        ref_mem[a] = d;
        @(negedge clk);
        pk_we = 1'b0;
    endtask

    task automatic run_access(input logic we, input logic [31:0] a, input logic [1:0] nb,
                              input logic [31:0] wd, input bit hold_req,
                              input int stall_at, input int stall_len);
        int          n;
        int          cnt;
        int          wr0;
        int          dc0;
        bit          seen;
        logic [31:0] exp_rd;
        logic [16:0] ma;
        n = nbytes(nb);
        exp_rd = 32'h0;
        for (int k = 0; k < n; k++) begin
            ma = 17'(a + 32'(k));
            if (we) ref_mem[ma] = wd[8*k +: 8];
            else exp_rd[8*k +: 8] = ref_mem[ma];
        end
        wr0 = wr_q.size();
        dc0 = done_cnt;
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = a; nbyte_i = nb; wdata_i = wd;
        @(posedge clk);
        @(negedge clk);
        req_i = hold_req; we_i = $urandom; addr_i = $urandom; nbyte_i = 2'($urandom); wdata_i = $urandom;
        check_val("busy_after_accept", 32'(busy_o), 32'd1);
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            if (stall_len > 0 && cnt == stall_at) begin
                rdy = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); cnt++; @(negedge clk);
                    check_val("stall_no_wr", 32'(mem_wr_o), 32'd0);
                end
                rdy = 1'b1;
            end
            @(posedge clk); cnt++; @(negedge clk);
            if (stall_len == 0 && cnt >= 1 && cnt <= n) begin
                check_val("mem_a_step", 32'(mem_a_o), 32'(17'(a + 32'(cnt - 1))));
                check_val("mem_wr_slot", 32'(mem_wr_o), 32'(we));
            end
            if (done_o) seen = 1'b1;
        end
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("latency", 32'(cnt), 32'(n + 2 + stall_len));
        check_val("fill_we", 32'(fill_we_o), 32'd1);
        check_val("busy_in_done", 32'(busy_o), 32'd1);
        check_val("fill_addr", fill_addr_o, a);
        check_val("fill_nbyte", 32'(fill_nbyte_o), (nb == 2'b11) ? 32'd2 : 32'(nb));
        check_val("fill_data", fill_data_o, we ? wd : exp_rd);
        check_val("rdata", rdata_o, we ? last_rd : exp_rd);
        if (!we) last_rd = exp_rd;
        @(posedge clk); @(negedge clk);
        check_val("busy_fall", 32'(busy_o), 32'd0);
        check_val("done_pulse", 32'(done_o), 32'd0);
        req_i = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("no_reaccept", 32'(busy_o), 32'd0);
        check_val("done_count", 32'(done_cnt - dc0), 32'd1);
        check_val("wr_count", 32'(wr_q.size() - wr0), we ? 32'(n) : 32'd0);
        if (we) begin
            for (int k = 0; k < n && (wr0 + k) < wr_q.size(); k++) begin
                check_val("wr_entry", 32'(wr_q[wr0 + k]), 32'({17'(a + 32'(k)), wd[8*k +: 8]}));
            end
        end
    endtask

    initial begin
        int          wr0;
        int          dc0;
        logic        we;
        logic [31:0] a;
        logic [1:0]  nb;
        int          sa;
        int          sl;
        errors = 0; checks = 0; last_rd = 32'h0;
        rst = 1'b0; rdy = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0;
        nbyte_i = 2'b00; wdata_i = 32'h0; pk_we = 1'b0; pk_a = 17'h0; pk_d = 8'h0;
        ram_clr = 1'b1;
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = bg(17'(i));
        @(posedge clk);
        @(negedge clk);
        ram_clr = 1'b0;
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_mem_wr", 32'(mem_wr_o), 32'd0);
        check_val("rst_fill_we", 32'(fill_we_o), 32'd0);
        check_val("rst_rdata", rdata_o, 32'd0);
        check_val("rst_mem_a", 32'(mem_a_o), 32'd0);
        check_val("rst_fill_addr", fill_addr_o, 32'd0);
        check_val("rst_fill_data", fill_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
        run_access(1'b0, 32'h0000_0100, 2'b10, 32'h0, 1'b0, 0, 0);
        check_val("load4_value", last_rd, 32'h4433_2211);
        run_access(1'b1, 32'h0001_FFFF, 2'b01, 32'hCAFE_BABE, 1'b0, 0, 0);
        run_access(1'b0, 32'h0001_FFFF, 2'b01, 32'h0, 1'b0, 0, 0);
        check_val("wrap_readback", last_rd, 32'h0000_BABE);
        poke(17'h050, 8'hF0);
        run_access(1'b0, 32'h0000_0050, 2'b00, 32'h0, 1'b0, 0, 0);
        check_val("load1_value", last_rd, 32'h0000_00F0);
        run_access(1'b0, 32'h0000_0100, 2'b11, 32'h0, 1'b0, 0, 0);
        run_access(1'b0, 32'h0000_0200, 2'b10, 32'h0, 1'b1, 0, 0);
        run_access(1'b1, 32'h0000_0400, 2'b10, 32'h0BAD_F00D, 1'b0, 2, 3);
        run_access(1'b0, 32'h0000_0400, 2'b10, 32'h0, 1'b0, 0, 0);
        check_val("stall_readback", last_rd, 32'h0BAD_F00D);
        run_access(1'b0, 32'hFFFF_FFFF, 2'b10, 32'h0, 1'b0, 0, 0);

        // Reset during store byte 1: only byte 0 reaches RAM, no done
        wr0 = wr_q.size();
        dc0 = done_cnt;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h300; nbyte_i = 2'b10; wdata_i = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        req_i = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check_val("pre_rst_wr", 32'(mem_wr_o), 32'd1);
        check_val("pre_rst_addr", 32'(mem_a_o), 32'h301);
        rst = 1'b0;
        #1;
        check_val("rst_mid_wr", 32'(mem_wr_o), 32'd0);
        check_val("rst_mid_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_val("rst_no_done", 32'(done_cnt - dc0), 32'd0);
        check_val("rst_idle", 32'(busy_o), 32'd0);
        check_val("rst_partial_wr", 32'(wr_q.size() - wr0), 32'd1);
        check_val("rst_rdata_clr", rdata_o, 32'd0);
        ref_mem[17'h300] = 8'h78;
        last_rd = 32'h0;
        run_access(1'b0, 32'h300, 2'b01, 32'h0, 1'b0, 0, 0);
        check_val("rst_partial_rd", last_rd, {16'h0, ref_mem[17'h301], 8'h78});

        for (int i = 0; i < 30; i++) begin
            we = 1'($urandom);
            nb = 2'($urandom);
            case ($urandom % 4)
                0:       a = 32'h0001_FFFC + ($urandom % 4);
                1:       a = 32'h0000_0600 + ($urandom % 8);
                2:       a = 32'hFFFF_FFFC + ($urandom % 4);
                default: a = $urandom;
            endcase
            sa = 0;
            sl = 0;
            if (we && ($urandom % 2 == 1)) begin
                sa = 1 + int'($urandom % nbytes(nb));
                sl = 1 + int'($urandom % 3);
            end
            run_access(we, a, nb, $urandom, 1'($urandom), sa, sl);
            repeat ($urandom % 3) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
